// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the small FIFO family: depth from address bits and a ceil-log2.
package fifo_pkg;

  function automatic int unsigned fifo_depth(input int unsigned depth_bits);
    return 32'd1 << depth_bits;
  endfunction

  // Smallest bit count that can address `value` entries (minimum 1).
  function automatic int unsigned fifo_clog2(input int unsigned value);
    int unsigned bits;
    bits = 32'd1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) bits = 32'(i + 1);
    end
    return bits;
  endfunction

endpackage

// File: rtl/fwft_small_fifo_if.sv
// Push/pop handshake and status bundle for fwft_small_fifo; master is the user, slave is the FIFO.
interface fwft_small_fifo_if #(
  parameter int unsigned WIDTH = 72
);
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             nearly_full;
  logic             prog_full;
  logic             empty;

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, nearly_full, prog_full, empty
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, nearly_full, prog_full, empty
  );
endinterface

// File: rtl/small_fifo_ram.sv
// WIDTH x DEPTH register array: synchronous write port, asynchronous (combinational) read port.
module small_fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 72,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_BITS = fifo_clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the FIFO pointers define which words are live, so
  // clearing the array would only cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fwft_small_fifo.sv
// First-word-fall-through FIFO: head word is on dout whenever empty=0, rd_en acknowledges it.
// Define FWFT_FIFO_ERROR_CHECK_EN for simulation-only overflow/underflow messages.
module fwft_small_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH               = 72,
  parameter int unsigned MAX_DEPTH_BITS      = 3,
  parameter int unsigned PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
  input logic              clk,
  input logic              reset,
  fwft_small_fifo_if.slave bus
);

  localparam int unsigned DEPTH = fifo_depth(MAX_DEPTH_BITS);
  localparam int unsigned CW    = MAX_DEPTH_BITS + 1;

  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [CW-1:0]             count;
  logic [WIDTH-1:0]          rdata;
  logic                      empty;
  logic                      full;
  logic                      wr_accept;
  logic                      rd_accept;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A write into a full FIFO still lands when the head is popped in the same cycle.
  assign rd_accept = bus.rd_en & ~empty;
  assign wr_accept = bus.wr_en & (~full | rd_accept);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
      if (rd_accept) rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
      unique case ({wr_accept, rd_accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  small_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign bus.dout        = empty ? '0 : rdata;
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.nearly_full = (count >= CW'(DEPTH - 1));
  // Widened compare so a threshold above DEPTH simply never matches.
  assign bus.prog_full   = (32'(count) >= PROG_FULL_THRESHOLD);

`ifdef FWFT_FIFO_ERROR_CHECK_EN
  always @(posedge clk) begin
    if (reset) begin
      if (bus.wr_en && full && !bus.rd_en)
        $display("%t %m ERROR: write to full fifo", $time);
      if (bus.rd_en && empty)
        $display("%t %m ERROR: read from empty fifo", $time);
    end
  end
`endif

endmodule

// File: tb/tb_fwft_small_fifo.sv
// Directed bench for fwft_small_fifo (27 bits x 4): queue-based reference model checked every cycle.
module tb_fwft_small_fifo;

  localparam int unsigned WIDTH = 27;
  localparam int unsigned BITS  = 2;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;

  fwft_small_fifo_if #(.WIDTH(WIDTH)) bus ();

  fwft_small_fifo #(
    .WIDTH          (WIDTH),
    .MAX_DEPTH_BITS (BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Reference model: contents as a plain queue, head at index 0.
  logic [WIDTH-1:0] model_q [$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
    end else begin
      automatic bit do_rd = bus.rd_en && (model_q.size() > 0);
      automatic bit do_wr = bus.wr_en && ((model_q.size() < DEPTH) || do_rd);
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(bus.din);
    end
  end

  // Compare process: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    automatic int n = model_q.size();
    check("empty",       32'(bus.empty),       32'(n == 0));
    check("full",        32'(bus.full),        32'(n == DEPTH));
    check("nearly_full", 32'(bus.nearly_full), 32'(n >= DEPTH - 1));
    check("prog_full",   32'(bus.prog_full),   32'(n >= DEPTH - 1));
    check("dout",        32'(bus.dout),        (n == 0) ? 32'd0 : 32'(model_q[0]));
  end

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.din   = d;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [WIDTH-1:0] val);
    check(name, 32'(bus.dout), 32'(val));
    step(1'b0, 1'b1, '0);
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 1: reset then idle
    step(1'b0, 1'b0, '0);
    check("t1_empty", 32'(bus.empty), 32'd1);
    check("t1_full",  32'(bus.full),  32'd0);
    check("t1_nf",    32'(bus.nearly_full), 32'd0);
    check("t1_pf",    32'(bus.prog_full),   32'd0);
    check("t1_dout",  32'(bus.dout),  32'd0);

    // 2: single write falls through, one read empties
    step(1'b1, 1'b0, 27'h1234567);
    check("t2_empty", 32'(bus.empty), 32'd0);
    check("t2_dout",  32'(bus.dout),  32'h1234567);
    step(1'b0, 1'b0, '0);
    check("t2_hold",  32'(bus.dout),  32'h1234567);
    step(1'b0, 1'b1, '0);
    check("t2_empty_after", 32'(bus.empty), 32'd1);
    check("t2_dout_after",  32'(bus.dout),  32'd0);

    // 3: fill, overflow dropped, drain in order
    step(1'b1, 1'b0, 27'd1);
    step(1'b1, 1'b0, 27'd2);
    check("t3_nf_2", 32'(bus.nearly_full), 32'd0);
    step(1'b1, 1'b0, 27'd3);
    check("t3_nf_3", 32'(bus.nearly_full), 32'd1);
    check("t3_pf_3", 32'(bus.prog_full),   32'd1);
    check("t3_full_3", 32'(bus.full),      32'd0);
    step(1'b1, 1'b0, 27'd4);
    check("t3_full_4", 32'(bus.full), 32'd1);
    step(1'b1, 1'b0, 27'd5);
    check("t3_full_5", 32'(bus.full), 32'd1);
    pop_expect("t3_rd1", 27'd1);
    pop_expect("t3_rd2", 27'd2);
    pop_expect("t3_rd3", 27'd3);
    pop_expect("t3_rd4", 27'd4);
    check("t3_empty", 32'(bus.empty), 32'd1);

    // 4: simultaneous push/pop while full
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 27'(i));
    step(1'b1, 1'b1, 27'd9);
    check("t4_full", 32'(bus.full), 32'd1);
    check("t4_head", 32'(bus.dout), 32'd2);
    pop_expect("t4_rd2", 27'd2);
    pop_expect("t4_rd3", 27'd3);
    pop_expect("t4_rd4", 27'd4);
    pop_expect("t4_rd9", 27'd9);
    check("t4_empty", 32'(bus.empty), 32'd1);

    // 5: read ignored on empty, write still accepted
    step(1'b1, 1'b1, 27'd7);
    check("t5_empty", 32'(bus.empty), 32'd0);
    check("t5_dout",  32'(bus.dout),  32'd7);
    step(1'b0, 1'b1, '0);

    // 6: asynchronous reset mid-clock with three words held
    step(1'b1, 1'b0, 27'h11);
    step(1'b1, 1'b0, 27'h22);
    step(1'b1, 1'b0, 27'h33);
    check("t6_pre_count", 32'(bus.nearly_full), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_empty_now", 32'(bus.empty), 32'd1);
    check("t6_full_now",  32'(bus.full),  32'd0);
    check("t6_dout_now",  32'(bus.dout),  32'd0);
    #4 reset = 1'b1;
    step(1'b1, 1'b0, 27'h5a5);
    check("t6_new_word", 32'(bus.dout), 32'h5a5);
    pop_expect("t6_rd_new", 27'h5a5);
    check("t6_empty_end", 32'(bus.empty), 32'd1);

    step(1'b0, 1'b0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
